// File: rtl/pusch_rx_pkg.sv
// Shared PUSCH receive-chain constants, FSM encoding and IQ payload type.
package pusch_rx_pkg;

    localparam int unsigned WIDTH         = 26;
    localparam int unsigned FFT_SIZE      = 2048;
    localparam int unsigned CP_LONG       = 160;
    localparam int unsigned CP_SHORT      = 144;
    localparam int unsigned SYMS_PER_SLOT = 14;
    localparam int unsigned LONG_SYM_A    = 0;
    localparam int unsigned LONG_SYM_B    = 7;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned SYM_W  = 4;
    localparam int unsigned CNT_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CP   = 2'd1,
        ST_DATA = 2'd2
    } cp_state_t;

    typedef struct packed {
        logic signed [WIDTH-1:0] r;
        logic signed [WIDTH-1:0] i;
    } iq_t;

    // CP length of the symbol currently being received
    function automatic logic [CNT_W-1:0] cp_len(input logic [SYM_W-1:0] sym);
        return (sym == SYM_W'(LONG_SYM_A) || sym == SYM_W'(LONG_SYM_B)) ?
               CNT_W'(CP_LONG) : CNT_W'(CP_SHORT);
    endfunction

endpackage

// File: rtl/cp_remover_if.sv
// Sample stream into and useful-sample stream out of the CP remover.
interface cp_remover_if;

    logic                                     in_valid;
    logic                                     in_sos;
    logic signed [pusch_rx_pkg::WIDTH-1:0]    in_r;
    logic signed [pusch_rx_pkg::WIDTH-1:0]    in_i;
    logic                                     out_valid;
    logic signed [pusch_rx_pkg::WIDTH-1:0]    out_r;
    logic signed [pusch_rx_pkg::WIDTH-1:0]    out_i;
    logic [pusch_rx_pkg::ADDR_W-1:0]          out_addr;
    logic [pusch_rx_pkg::SYM_W-1:0]           out_sym;
    logic                                     out_sof;
    logic                                     out_eos;
    logic                                     slot_done;
    logic                                     sync_err;

    modport master (
        output in_valid, in_sos, in_r, in_i,
        input  out_valid, out_r, out_i, out_addr, out_sym,
               out_sof, out_eos, slot_done, sync_err
    );

    modport slave (
        input  in_valid, in_sos, in_r, in_i,
        output out_valid, out_r, out_i, out_addr, out_sym,
               out_sof, out_eos, slot_done, sync_err
    );

endinterface

// File: rtl/cp_sym_tracker.sv
// Slot/symbol position tracker: decides per accepted sample whether it is CP or useful data.
module cp_sym_tracker
    import pusch_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              sos,
    output logic              keep_c,
    output logic              sof_c,
    output logic              eos_c,
    output logic              restart_c,
    output logic              locked_c,
    output logic              boundary_expected_c,
    output logic [ADDR_W-1:0] addr_c,
    output logic [SYM_W-1:0]  sym
);

    cp_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SYM_W-1:0] sym_nxt;
    logic [CNT_W-1:0] cur_cp_len;

    assign cur_cp_len = cp_len(sym);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt spans the whole symbol: CP at 0..cp_len-1, useful data after that
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sym <= '0;
        end else begin
            cnt <= cnt_nxt;
            sym <= sym_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sym_nxt   = sym;
        if (valid && sos) begin
            state_nxt = ST_CP;
            cnt_nxt   = CNT_W'(1);
            sym_nxt   = '0;
        end else if (valid) begin
            case (state)
                ST_CP: begin
                    if (cnt == cur_cp_len - CNT_W'(1)) begin
                        state_nxt = ST_DATA;
                    end
                    cnt_nxt = cnt + CNT_W'(1);
                end
                ST_DATA: begin
                    if (cnt == cur_cp_len + CNT_W'(FFT_SIZE - 1)) begin
                        state_nxt = ST_CP;
                        cnt_nxt   = '0;
                        sym_nxt   = (sym == SYM_W'(SYMS_PER_SLOT - 1)) ? '0 : sym + SYM_W'(1);
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        keep_c              = 1'b0;
        restart_c           = valid && sos;
        locked_c            = (state != ST_IDLE);
        boundary_expected_c = (state == ST_CP) && (cnt == '0) && (sym == '0);
        addr_c              = ADDR_W'(cnt - cur_cp_len);
        if (valid && !sos && state == ST_DATA) begin
            keep_c = 1'b1;
        end
        sof_c = keep_c && (addr_c == '0);
        eos_c = keep_c && (addr_c == ADDR_W'(FFT_SIZE - 1));
    end

endmodule

// File: rtl/cp_remover.sv
// Cyclic-prefix remover: drops CP samples and forwards tagged useful samples to the FFT buffer.
module cp_remover
    import pusch_rx_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    cp_remover_if.slave  bus
);

    logic              keep_c, sof_c, eos_c, restart_c, locked_c, boundary_expected_c;
    logic [ADDR_W-1:0] addr_c;
    logic [SYM_W-1:0]  sym;
    iq_t               in_iq, out_iq;

    cp_sym_tracker u_tracker (
        .clk                 (clk),
        .rst                 (rst),
        .valid               (bus.in_valid),
        .sos                 (bus.in_sos),
        .keep_c              (keep_c),
        .sof_c               (sof_c),
        .eos_c               (eos_c),
        .restart_c           (restart_c),
        .locked_c            (locked_c),
        .boundary_expected_c (boundary_expected_c),
        .addr_c              (addr_c),
        .sym                 (sym)
    );

    assign in_iq = '{r: bus.in_r, i: bus.in_i};

    // Data and tags hold between useful samples; flags are single-cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_iq        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_addr  <= '0;
            bus.out_sym   <= '0;
            bus.out_sof   <= 1'b0;
            bus.out_eos   <= 1'b0;
            bus.slot_done <= 1'b0;
            bus.sync_err  <= 1'b0;
        end else begin
            bus.out_valid <= keep_c;
            bus.out_sof   <= sof_c;
            bus.out_eos   <= eos_c;
            bus.slot_done <= eos_c && (sym == SYM_W'(SYMS_PER_SLOT - 1));
            bus.sync_err  <= restart_c && locked_c && !boundary_expected_c;
            if (keep_c) begin
                out_iq       <= in_iq;
                bus.out_addr <= addr_c;
                bus.out_sym  <= sym;
            end
        end
    end

    assign bus.out_r = out_iq.r;
    assign bus.out_i = out_iq.i;

endmodule

// File: tb/tb_cp_remover.sv
// Self-checking bench for cp_remover against a slot-position reference model.
module tb_cp_remover;
    import pusch_rx_pkg::*;

    localparam int unsigned SLOT_LEN = 2 * (CP_LONG + FFT_SIZE) + 12 * (CP_SHORT + FFT_SIZE);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cp_remover_if bus ();

    cp_remover dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic              valid;
        logic [WIDTH-1:0]  r;
        logic [WIDTH-1:0]  i;
        logic [10:0]       addr;
        logic [3:0]        sym;
        logic              sof;
        logic              eos;
        logic              done;
        logic              err;
    } obs_t;

    typedef struct {
        logic v;
        logic s;
        logic exp_valid;
        logic exp_err;
    } vec_t;

    typedef struct {
        int unsigned pos;
        logic [10:0] addr;
        logic [3:0]  sym;
        logic        sof;
        logic        eos;
        logic        done;
    } spot_t;

    int n_checks = 0;
    int n_fail   = 0;

    bit          locked;
    int unsigned pos;
    obs_t        exp_o;
    int          dut_out_cnt;
    int          dut_err_cnt;
    spot_t       spots[5];
    vec_t        vecs[8];

    // Position within a slot -> (useful?, symbol, FFT address)
    function automatic void classify(input int unsigned p, output bit keep,
                                     output int unsigned s, output int unsigned a);
        int unsigned base = 0;
        keep = 1'b0;
        s    = 0;
        a    = 0;
        for (int unsigned sy = 0; sy < SYMS_PER_SLOT; sy++) begin
            int unsigned cpl = (sy == LONG_SYM_A || sy == LONG_SYM_B) ? CP_LONG : CP_SHORT;
            if (p < base + cpl + FFT_SIZE) begin
                s = sy;
                if (p >= base + cpl) begin
                    keep = 1'b1;
                    a    = p - base - cpl;
                end
                return;
            end
            base += cpl + FFT_SIZE;
        end
    endfunction

    function automatic obs_t get_obs();
        obs_t o;
        o.valid = bus.out_valid;
        o.r     = bus.out_r;
        o.i     = bus.out_i;
        o.addr  = bus.out_addr;
        o.sym   = bus.out_sym;
        o.sof   = bus.out_sof;
        o.eos   = bus.out_eos;
        o.done  = bus.slot_done;
        o.err   = bus.sync_err;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got v=%b r=%h i=%h addr=%0d sym=%0d sof=%b eos=%b done=%b err=%b, expected v=%b r=%h i=%h addr=%0d sym=%0d sof=%b eos=%b done=%b err=%b",
                     name, $time, act.valid, act.r, act.i, act.addr, act.sym, act.sof, act.eos,
                     act.done, act.err, exp.valid, exp.r, exp.i, exp.addr, exp.sym, exp.sof,
                     exp.eos, exp.done, exp.err);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        locked = 1'b0;
        pos    = 0;
        exp_o  = '0;
    endtask

    // One clock of stimulus, model update and output comparison
    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] r,
                        input logic [WIDTH-1:0] i);
        bit          keep;
        int unsigned sy, a, kpos;
        obs_t        o;
        keep = 1'b0;
        kpos = 0;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sos   = s;
        bus.in_r     = r;
        bus.in_i     = i;
        exp_o.valid  = 1'b0;
        exp_o.sof    = 1'b0;
        exp_o.eos    = 1'b0;
        exp_o.done   = 1'b0;
        exp_o.err    = 1'b0;
        if (v && s) begin
            exp_o.err = locked && (pos != 0);
            locked    = 1'b1;
            pos       = 1;
        end else if (v && locked) begin
            classify(pos, keep, sy, a);
            if (keep) begin
                kpos        = pos;
                exp_o.valid = 1'b1;
                exp_o.r     = r;
                exp_o.i     = i;
                exp_o.addr  = 11'(a);
                exp_o.sym   = 4'(sy);
                exp_o.sof   = (a == 0);
                exp_o.eos   = (a == FFT_SIZE - 1);
                exp_o.done  = (a == FFT_SIZE - 1) && (sy == SYMS_PER_SLOT - 1);
            end
            pos = (pos + 1) % SLOT_LEN;
        end
        @(posedge clk);
        #1;
        o = get_obs();
        check("cycle", o, exp_o);
        if (o.valid) dut_out_cnt++;
        if (o.err) dut_err_cnt++;
        if (keep) begin
            for (int k = 0; k < 5; k++) begin
                if (spots[k].pos == kpos) begin
                    n_checks++;
                    if ({o.valid, o.addr, o.sym, o.sof, o.eos, o.done} !==
                        {1'b1, spots[k].addr, spots[k].sym, spots[k].sof, spots[k].eos, spots[k].done}) begin
                        n_fail++;
                        $display("FAIL spot_pos%0d: got v=%b addr=%0d sym=%0d sof=%b eos=%b done=%b, expected addr=%0d sym=%0d sof=%b eos=%b done=%b",
                                 kpos, o.valid, o.addr, o.sym, o.sof, o.eos, o.done, spots[k].addr,
                                 spots[k].sym, spots[k].sof, spots[k].eos, spots[k].done);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_reset", get_obs(), '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", get_obs(), '0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_accepted(input int n, input int start_k, input int ratio);
        int got = 0;
        int k   = start_k;
        while (got < n) begin
            if (ratio == 0 || $urandom_range(3, 0) != 0) begin
                step(1'b1, 1'b0, WIDTH'(k), WIDTH'($urandom));
                k++;
                got++;
            end else begin
                step(1'b0, 1'b0, WIDTH'($urandom), WIDTH'($urandom));
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sos   = 1'b0;
        bus.in_r     = '0;
        bus.in_i     = '0;
        model_reset();

        spots[0] = '{pos: 160,   addr: 11'd0,    sym: 4'd0,  sof: 1'b1, eos: 1'b0, done: 1'b0};
        spots[1] = '{pos: 2207,  addr: 11'd2047, sym: 4'd0,  sof: 1'b0, eos: 1'b1, done: 1'b0};
        spots[2] = '{pos: 2352,  addr: 11'd0,    sym: 4'd1,  sof: 1'b1, eos: 1'b0, done: 1'b0};
        spots[3] = '{pos: 15520, addr: 11'd0,    sym: 4'd7,  sof: 1'b1, eos: 1'b0, done: 1'b0};
        spots[4] = '{pos: 30719, addr: 11'd2047, sym: 4'd13, sof: 1'b0, eos: 1'b1, done: 1'b1};

        vecs[0] = '{v: 1'b1, s: 1'b0, exp_valid: 1'b0, exp_err: 1'b0};
        vecs[1] = '{v: 1'b0, s: 1'b1, exp_valid: 1'b0, exp_err: 1'b0};
        vecs[2] = '{v: 1'b1, s: 1'b1, exp_valid: 1'b0, exp_err: 1'b0};
        vecs[3] = '{v: 1'b1, s: 1'b0, exp_valid: 1'b0, exp_err: 1'b0};
        vecs[4] = '{v: 1'b0, s: 1'b1, exp_valid: 1'b0, exp_err: 1'b0};
        vecs[5] = '{v: 1'b1, s: 1'b1, exp_valid: 1'b0, exp_err: 1'b1};
        vecs[6] = '{v: 1'b1, s: 1'b0, exp_valid: 1'b0, exp_err: 1'b0};
        vecs[7] = '{v: 1'b0, s: 1'b0, exp_valid: 1'b0, exp_err: 1'b0};

        #3 rst = 1'b0;
        #1 check("power_on_reset", get_obs(), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Lock/ignore rules in the first few CP samples
        for (int n = 0; n < 8; n++) begin
            step(vecs[n].v, vecs[n].s, WIDTH'($urandom), WIDTH'($urandom));
            n_checks++;
            if ({bus.out_valid, bus.sync_err} !== {vecs[n].exp_valid, vecs[n].exp_err}) begin
                n_fail++;
                $display("FAIL vec%0d: got valid=%b err=%b expected valid=%b err=%b", n,
                         bus.out_valid, bus.sync_err, vecs[n].exp_valid, vecs[n].exp_err);
            end
        end

        // Unlocked stream must produce nothing
        do_reset();
        dut_out_cnt = 0;
        dut_err_cnt = 0;
        run_accepted(2000, 0, 0);
        check_int("idle_outputs", dut_out_cnt, 0);
        check_int("idle_sync_err", dut_err_cnt, 0);

        // One continuous slot, sample value = k
        dut_out_cnt = 0;
        step(1'b1, 1'b1, '0, '0);
        run_accepted(int'(SLOT_LEN) - 1, 1, 0);
        check_int("slot_output_count", dut_out_cnt, int'(SYMS_PER_SLOT * FFT_SIZE));

        // Expected sos at the slot boundary, then gapped stream and free-running wrap
        dut_out_cnt = 0;
        dut_err_cnt = 0;
        step(1'b1, 1'b1, WIDTH'(SLOT_LEN), '0);
        for (int n = 0; n < 3000; n++) begin
            step(1'b1, 1'b0, WIDTH'(int'(SLOT_LEN) + 1 + n), WIDTH'(n));
            step(1'b0, 1'b0, WIDTH'($urandom), WIDTH'($urandom));
        end
        run_accepted(int'(SLOT_LEN) - 3001, 3001, 1);
        check_int("gapped_slot_output_count", dut_out_cnt, int'(SYMS_PER_SLOT * FFT_SIZE));
        run_accepted(2500, 0, 1);
        check_int("boundary_sync_err", dut_err_cnt, 0);

        // Mid-symbol re-sync at k=1000
        do_reset();
        dut_err_cnt = 0;
        step(1'b1, 1'b1, '0, '0);
        run_accepted(999, 1, 0);
        step(1'b1, 1'b1, WIDTH'(1000), '0);
        run_accepted(2500, 1, 0);
        check_int("resync_sync_err", dut_err_cnt, 1);

        // Reset in the middle of a slot drops everything until the next sos
        do_reset();
        step(1'b1, 1'b1, '0, '0);
        run_accepted(4999, 1, 0);
        do_reset();
        dut_out_cnt = 0;
        run_accepted(200, 0, 0);
        check_int("post_reset_outputs", dut_out_cnt, 0);
        step(1'b1, 1'b1, '0, '0);
        run_accepted(500, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
